// File: rtl/minicpu_data_responder.sv
// Memory-side responder for the miniCPU data_sram_* port: word RAM plus MMIO
// (LED register, free-running timer, console TX FIFO draining to a ready/valid sink).
module minicpu_data_responder #(
    parameter int unsigned RAM_DEPTH  = 1024,
    parameter logic [31:0] RAM_BASE   = 32'h1c01_0000,
    parameter logic [31:0] MMIO_BASE  = 32'hbfaf_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        bus_err
);

    localparam int unsigned IdxW = $clog2(RAM_DEPTH);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] RamEnd = RAM_BASE + 32'(RAM_DEPTH * 4);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    logic [31:0] ram_mem [RAM_DEPTH];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [15:0]     led_q, led_d;
    logic [31:0]     timer_q, timer_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            bus_err_q, bus_err_d;

    logic            ram_hit, mmio_hit;
    logic [1:0]      mmio_off;
    logic [IdxW-1:0] ram_idx;
    logic            wr_led, wr_timer, wr_tx, wr_st;
    logic            full, empty, push, pop;
    logic [31:0]     status;

    assign ram_hit  = (data_sram_addr >= RAM_BASE) && (data_sram_addr < RamEnd);
    assign mmio_hit = (data_sram_addr[31:4] == MMIO_BASE[31:4]);
    assign mmio_off = data_sram_addr[3:2];
    assign ram_idx  = data_sram_addr[IdxW+1:2];

    assign wr_led   = data_sram_we && mmio_hit && (mmio_off == 2'd0);
    assign wr_timer = data_sram_we && mmio_hit && (mmio_off == 2'd1);
    assign wr_tx    = data_sram_we && mmio_hit && (mmio_off == 2'd2);
    assign wr_st    = data_sram_we && mmio_hit && (mmio_off == 2'd3);

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);
    assign pop   = !empty && con_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = wr_tx && (!full || pop);

    assign status = {20'b0, 4'(count_q), 5'b0, ovf_q, full, empty};

    always_comb begin
        led_d     = led_q;
        timer_d   = timer_q + 32'd1;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CntW'(push) - CntW'(pop);
        ovf_d     = ovf_q;
        bus_err_d = data_sram_we && !ram_hit && !mmio_hit;
        if (wr_led)   led_d   = data_sram_wdata[15:0];
        if (wr_timer) timer_d = data_sram_wdata;
        if (push)     wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (wr_st)    ovf_d = 1'b0;
        if (wr_tx && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            timer_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            timer_q   <= timer_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Storage arrays carry no reset; FIFO validity lives in count_q.
    always_ff @(posedge clk) begin
        if (data_sram_we && ram_hit) ram_mem[ram_idx] <= data_sram_wdata;
        if (push && !reset) fifo_mem[wr_ptr_q] <= data_sram_wdata[7:0];
    end

    always_comb begin
        data_sram_rdata = '0;
        if (ram_hit) begin
            data_sram_rdata = ram_mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                2'd0:    data_sram_rdata = {16'b0, led_q};
                2'd1:    data_sram_rdata = timer_q;
                2'd3:    data_sram_rdata = status;
                default: data_sram_rdata = '0;
            endcase
        end
    end

    assign led       = led_q;
    assign con_valid = !empty;
    assign con_data  = empty ? 8'h00 : fifo_mem[rd_ptr_q];
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_minicpu_data_responder.sv
// Directed self-checking bench for minicpu_data_responder: RAM, LED, timer,
// console FIFO (fill, overflow, drain, push-while-full-pop) and bus_err.
module tb_minicpu_data_responder;

    localparam logic [31:0] A_LED   = 32'hbfaf_0000;
    localparam logic [31:0] A_TIMER = 32'hbfaf_0004;
    localparam logic [31:0] A_TX    = 32'hbfaf_0008;
    localparam logic [31:0] A_ST    = 32'hbfaf_000c;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    minicpu_data_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led),
        .con_valid       (con_valid),
        .con_data        (con_data),
        .con_ready       (con_ready),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        data_sram_we    = we;
        data_sram_addr  = a;
        data_sram_wdata = d;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] drain5 [8];
        drain5 = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5a};

        // Reset state
        reset = 1'b1;
        con_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        drive(1'b0, A_TIMER, 32'h0);
        check("rst_timer", data_sram_rdata, 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_con_valid", 32'(con_valid), 32'h0);
        check("rst_con_data", 32'(con_data), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        reset = 1'b0;

        // RAM: same-cycle read returns prior value, next cycle the new one
        drive(1'b1, 32'h1c01_0010, 32'h1111_1111);
        tick();
        drive(1'b1, 32'h1c01_0010, 32'hdead_beef);
        check("ram_rd_during_wr", data_sram_rdata, 32'h1111_1111);
        tick();
        drive(1'b0, 32'h1c01_0010, 32'h0);
        check("ram_rd_after_wr", data_sram_rdata, 32'hdead_beef);
        drive(1'b1, 32'h1c01_0ffc, 32'hcafe_f00d);
        tick();
        drive(1'b0, 32'h1c01_0ffc, 32'h0);
        check("ram_last_word", data_sram_rdata, 32'hcafe_f00d);
        check("ram_no_bus_err", 32'(bus_err), 32'h0);
        // One past the end of RAM is unmapped
        drive(1'b1, 32'h1c01_1000, 32'h5);
        tick();
        drive(1'b0, 32'h1c01_1000, 32'h0);
        check("ram_end_bus_err", 32'(bus_err), 32'h1);
        check("ram_end_rdata", data_sram_rdata, 32'h0);
        tick();
        check("ram_end_err_pulse", 32'(bus_err), 32'h0);

        // LED
        drive(1'b1, A_LED, 32'habcd_1234);
        check("led_before_edge", 32'(led), 32'h0);
        tick();
        drive(1'b0, A_LED, 32'h0);
        check("led_out", 32'(led), 32'h1234);
        check("led_read", data_sram_rdata, 32'h0000_1234);

        // Timer load and wrap
        drive(1'b1, A_TIMER, 32'hffff_fffe);
        tick();
        drive(1'b0, A_TIMER, 32'h0);
        check("timer_load", data_sram_rdata, 32'hffff_fffe);
        tick();
        check("timer_p1", data_sram_rdata, 32'hffff_ffff);
        tick();
        check("timer_wrap", data_sram_rdata, 32'h0);
        tick();
        check("timer_p3", data_sram_rdata, 32'h1);

        // FIFO fill, overflow, drain
        con_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, A_TX, 32'(8'h41 + i));
            if (i == 0) check("push_empty_no_bypass", 32'(con_valid), 32'h0);
            tick();
        end
        drive(1'b0, A_ST, 32'h0);
        check("st_full", data_sram_rdata, 32'h0000_0802);
        drive(1'b1, A_TX, 32'h49);
        check("tx_read_zero", data_sram_rdata, 32'h0);
        tick();
        drive(1'b0, A_ST, 32'h0);
        check("st_ovf", data_sram_rdata, 32'h0000_0806);
        check("head_stable", 32'(con_data), 32'h41);
        tick();
        check("head_stable2", 32'(con_data), 32'h41);
        con_ready = 1'b1;
        drive(1'b0, A_LED, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check("drain4_valid", 32'(con_valid), 32'h1);
            check("drain4_data", 32'(con_data), 32'(8'h41 + i));
            tick();
        end
        check("drain4_empty", 32'(con_valid), 32'h0);
        drive(1'b0, A_ST, 32'h0);
        check("st_empty_ovf", data_sram_rdata, 32'h0000_0005);
        drive(1'b1, A_ST, 32'h0);
        tick();
        drive(1'b0, A_ST, 32'h0);
        check("st_ovf_cleared", data_sram_rdata, 32'h0000_0001);

        // Push while full with simultaneous pop
        con_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, A_TX, 32'(8'h41 + i));
            tick();
        end
        con_ready = 1'b1;
        drive(1'b1, A_TX, 32'h5a);
        check("full_pop_head", 32'(con_data), 32'h41);
        tick();
        drive(1'b0, A_ST, 32'h0);
        check("full_pop_st", data_sram_rdata, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            check("drain5_data", 32'(con_data), 32'(drain5[i]));
            tick();
        end
        check("drain5_empty", 32'(con_valid), 32'h0);

        // Unmapped access
        drive(1'b1, 32'h0000_0100, 32'h1);
        check("err_before_edge", 32'(bus_err), 32'h0);
        tick();
        drive(1'b0, 32'h0000_0100, 32'h0);
        check("err_pulse", 32'(bus_err), 32'h1);
        check("err_rdata", data_sram_rdata, 32'h0);
        tick();
        check("err_read_no_flag", 32'(bus_err), 32'h0);

        // Reset mid-drain flushes FIFO and clears LED
        con_ready = 1'b0;
        drive(1'b1, A_TX, 32'h51);
        tick();
        drive(1'b1, A_TX, 32'h52);
        tick();
        drive(1'b0, A_LED, 32'h0);
        check("pre_rst_valid", 32'(con_valid), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, A_ST, 32'h0);
        check("flush_valid", 32'(con_valid), 32'h0);
        check("flush_data", 32'(con_data), 32'h0);
        check("flush_st", data_sram_rdata, 32'h0000_0001);
        check("rst_led_again", 32'(led), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
